// File: rtl/ysyx_24100006_pkg.sv
// Shared definitions for the ysyx_24100006 instruction fetch unit:
// FSM state encoding, fetch exception cause codes and default reset PC.
package ysyx_24100006_pkg;

   typedef enum logic [1:0] {
      S_AR  = 2'd0,
      S_R   = 2'd1,
      S_OUT = 2'd2
   } ifu_state_e;

   localparam logic [7:0]  FETCH_MISALIGN   = 8'd0;
   localparam logic [7:0]  FETCH_FAULT      = 8'd1;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

endpackage

// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch unit: AR -> R -> OUT bus sequencer with redirect/drop handling.
// Optional macro YSYX_24100006_IFU_MISALIGN_CHECK_EN enables misaligned-target exceptions.
module ysyx_24100006_ifu
   import ysyx_24100006_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic        arvalid_o,
   input  logic        arready_i,
   output logic [31:0] araddr_o,
   input  logic        rvalid_i,
   output logic        rready_o,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_add_4_o,
   output logic        irq_o,
   output logic [7:0]  irq_no_o
);

   ifu_state_e  state, state_d;
   logic [31:0] pc, pc_d;
   logic [31:0] ar_addr, ar_d;
   logic        drop, drop_d;
   logic        ld_beat, ld_fault;
   logic [31:0] tgt, nxt;
   logic        ar_mis;

`ifdef YSYX_24100006_IFU_MISALIGN_CHECK_EN
   assign tgt    = redirect_pc_i;
   assign ar_mis = (ar_addr[1:0] != 2'b00);
`else
   assign tgt    = redirect_pc_i & 32'hFFFF_FFFC;
   assign ar_mis = 1'b0;
`endif

   // pc is the next address to fetch; ar_addr is the address of the request on the bus.
   // They differ only while a dropped request is still outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_AR;
         pc      <= RESET_PC;
         ar_addr <= RESET_PC;
         drop    <= 1'b0;
      end else begin
         state   <= state_d;
         pc      <= pc_d;
         ar_addr <= ar_d;
         drop    <= drop_d;
      end
   end

   always_comb begin
      state_d  = state;
      pc_d     = pc;
      ar_d     = ar_addr;
      drop_d   = drop;
      ld_beat  = 1'b0;
      ld_fault = 1'b0;
      nxt      = pc;
      case (state)
         S_AR: begin
            if (ar_mis) begin
               // no request was issued, so a redirect simply replaces the target
               if (flush_i) begin
                  pc_d = tgt;
                  ar_d = tgt;
               end else begin
                  ld_fault = 1'b1;
                  state_d  = S_OUT;
               end
            end else begin
               if (flush_i) begin
                  pc_d   = tgt;
                  drop_d = 1'b1;
               end
               if (arready_i) state_d = S_R;
            end
         end
         S_R: begin
            if (rvalid_i) begin
               if (drop || flush_i) begin
                  nxt     = flush_i ? tgt : pc;
                  pc_d    = nxt;
                  ar_d    = nxt;
                  drop_d  = 1'b0;
                  state_d = S_AR;
               end else begin
                  ld_beat = 1'b1;
                  state_d = S_OUT;
               end
            end else if (flush_i) begin
               pc_d   = tgt;
               drop_d = 1'b1;
            end
         end
         S_OUT: begin
            if (flush_i) begin
               pc_d    = tgt;
               ar_d    = tgt;
               state_d = S_AR;
            end else if (out_ready) begin
               pc_d    = pc + 32'd4;
               ar_d    = pc + 32'd4;
               state_d = S_AR;
            end
         end
         default: state_d = S_AR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instruction_o <= '0;
         pc_o          <= '0;
         pc_add_4_o    <= '0;
         irq_o         <= 1'b0;
         irq_no_o      <= '0;
      end else if (ld_beat) begin
         instruction_o <= rdata_i;
         pc_o          <= ar_addr;
         pc_add_4_o    <= ar_addr + 32'd4;
         irq_o         <= (rresp_i != 2'b00);
         irq_no_o      <= (rresp_i != 2'b00) ? FETCH_FAULT : '0;
      end else if (ld_fault) begin
         instruction_o <= '0;
         pc_o          <= ar_addr;
         pc_add_4_o    <= ar_addr + 32'd4;
         irq_o         <= 1'b1;
         irq_no_o      <= FETCH_MISALIGN;
      end
   end

   // gated by reset so nothing is requested while the bus is held in reset
   assign arvalid_o = reset && (state == S_AR) && !ar_mis;
   assign araddr_o  = ar_addr;
   assign rready_o  = reset && (state == S_R);
   assign out_valid = (state == S_OUT);

endmodule

// File: doc/ysyx_24100006_ifu.md
YSYX_24100006_IFU -- requirements
Module: ysyx_24100006_IFU

Interface
REQ-001 Parameter RESET_PC, default 32'h3000_0000, is the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 flush_i  in  1  redirect request from the back end, one cycle wide.
REQ-005 redirect_pc_i  in  32  redirect target, valid with flush_i.
REQ-006 arvalid_o / arready_i / araddr_o  out/in/out  1/1/32  instruction read-address channel.
REQ-007 rvalid_i / rready_o / rdata_i / rresp_i  in/out/in/in  1/1/32/2  instruction read-data channel.
REQ-008 out_valid / out_ready  out/in  1/1  handshake toward the IF/ID register.
REQ-009 instruction_o, pc_o, pc_add_4_o  out  32 each  fetched word, its address, address+4.
REQ-010 irq_o / irq_no_o  out  1/8  fetch exception flag and cause code.

Function
REQ-011 States: AR (drive arvalid_o=1, araddr_o=pc), R (drive rready_o=1), OUT (drive out_valid=1); no other outputs asserted in any state.
REQ-012 AR->R on arready_i; R->OUT on rvalid_i (latch rdata_i, pc, pc+4, rresp_i); OUT->AR on out_ready, with pc <= pc+4.
REQ-013 araddr_o SHALL stay stable while arvalid_o=1 and unaccepted; arvalid_o never drops before arready_i.
REQ-014 Minimum latency: AR-state entry to out_valid = 2 cycles (arready_i in cycle 0, rvalid_i in cycle 1, out_valid in cycle 2).
REQ-015 Outputs in OUT SHALL hold stable until out_ready; the register does not advance without the handshake.
REQ-016 pc_add_4_o = pc_o + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-017 rresp_i != 0 SHALL produce irq_o=1, irq_no_o=8'd1 with the beat in OUT; otherwise irq_o=0, irq_no_o=0.
REQ-018 flush_i in OUT: out_valid drops next cycle, pc <= redirect_pc_i, next state AR; flush wins over a simultaneous out_ready.
REQ-019 flush_i in AR or R: set drop flag, pc <= redirect_pc_i; outstanding transaction completes normally; its response is discarded (no OUT); then AR with the new pc.
REQ-020 flush_i while drop already set: pc takes the latest redirect_pc_i; only one drop per outstanding transaction.
REQ-021 flush_i in AR on the same cycle as arready_i: treated as flush in R (response dropped).

Reset
REQ-022 Reset asserted: state AR-pending, pc=RESET_PC, drop=0, out_valid=0, arvalid_o=0, rready_o=0, instruction_o/pc_o/pc_add_4_o=0, irq_o=0, irq_no_o=0.
REQ-023 First cycle after reset release: arvalid_o=1, araddr_o=RESET_PC.
REQ-024 Reset mid-transaction abandons it; no drop flag survives reset; the bench holds the memory model in reset simultaneously.

Configuration
REQ-025 YSYX_24100006_IFU_MISALIGN_CHECK_EN defined: redirect target with pc[1:0]!=0 issues no bus access and goes directly to OUT with irq_o=1, irq_no_o=8'd0, instruction_o=0.
REQ-026 Macro undefined: redirect_pc_i[1:0] forced to 2'b00; no misalignment exception exists.

Structure
REQ-027 Shared package ysyx_24100006_pkg holds the state encoding, IRQ cause constants (FETCH_MISALIGN=0, FETCH_FAULT=1) and default RESET_PC.
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 Reset release, arready_i=1 immediately, rvalid_i next cycle with rdata 0x00000013, out_ready=1 -> out_valid at cycle 2, pc_o=0x3000_0000, pc_add_4_o=0x3000_0004, next araddr_o=0x3000_0004.
REQ-030 out_ready=0 for 5 cycles in OUT -> outputs frozen, no new arvalid_o; out_ready=1 -> advance once.
REQ-031 flush_i to 0x8000_0000 while in R -> in-flight rdata 0xDEADBEEF never appears on out_valid; next araddr_o=0x8000_0000.
REQ-032 rresp_i=2'b10 -> irq_o=1, irq_no_o=1, pc_o equals the faulting address.
REQ-033 Macro defined, flush_i to 0x8000_0002 -> no arvalid_o, out_valid with irq_o=1, irq_no_o=0; macro undefined -> araddr_o=0x8000_0000.
REQ-034 flush_i and out_ready together in OUT -> pc becomes redirect target, not pc+4.
